// File: rtl/banked_coderom.sv
// Banked program ROM: NBANKS loadable banks, lowest active-low ce_n wins; rd accepted at T gives valid at T+1+WAIT.
// One read in flight at a time; busy high while pending, rd ignored until it drops; loads always accepted.
module banked_coderom #(
  parameter int NBANKS = 4,
  parameter int AW     = 13,
  parameter int DW     = 8,
  parameter int WAIT   = 0,
  localparam int BW    = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     a,
  input  logic [NBANKS-1:0] ce_n,
  input  logic              rd,
  output logic [DW-1:0]     out,
  output logic              valid,
  output logic              busy,
  output logic              multi_sel,
  input  logic              ld_en,
  input  logic [BW-1:0]     ld_bank,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DW-1:0]     ld_data
);

  typedef enum logic [1:0] {IDLE, WAITING, DATA} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [AW-1:0]     a_q;
  logic [BW-1:0]     bank_q;
  logic [BW-1:0]     sel_bank;
  logic [NBANKS-1:0] sel;
  logic              any_sel;
  logic              many_sel;
  logic              accept;
  logic              ld_ok;
  logic              ld_hit;
  logic [DW-1:0]     rd_word;

  logic [DW-1:0] mem [NBANKS][2**AW];

  assign sel      = ~ce_n;
  assign any_sel  = |sel;
  assign many_sel = |(sel & (sel - NBANKS'(1)));
  assign accept   = (state == IDLE) && rd && !ld_en && any_sel;
  assign ld_ok    = ld_en && (int'(ld_bank) < NBANKS);

  // Scan downward so the lowest-index enabled bank is the last (winning) assignment.
  always_comb begin
    sel_bank = '0;
    for (int i = NBANKS - 1; i >= 0; i--) begin
      if (!ce_n[i]) sel_bank = BW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (ld_ok) mem[ld_bank][ld_addr] <= ld_data;
  end

  // A load landing on the same edge as the data fetch is returned by that fetch.
  assign ld_hit = ld_ok && (ld_bank == bank_q) && (ld_addr == a_q);

  always_comb begin
    rd_word = mem[bank_q][a_q];
    if (ld_hit) rd_word = ld_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      out       <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      multi_sel <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            a_q    <= a;
            bank_q <= sel_bank;
            busy   <= 1'b1;
            if (many_sel) multi_sel <= 1'b1;
            if (WAIT == 0) begin
              state <= DATA;
            end else begin
              state <= WAITING;
              cnt   <= 4'(WAIT);
            end
          end
        end
        WAITING: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= DATA;
        end
        DATA: begin
          out   <= rd_word;
          valid <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_banked_coderom.sv
// Bench for banked_coderom: two instances (WAIT=0 and WAIT=3) with private read ports and a shared load port,
// randomized plus directed reads scored against a memory model through per-instance expectation queues.
module tb_banked_coderom;
  localparam int NB = 4;
  localparam int AW = 13;
  localparam int DW = 8;

  typedef struct {
    int   bank;
    int   addr;
    int   due;
    logic msel;
  } exp_t;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] a_v    [2];
  logic [NB-1:0] ce_v   [2];
  logic          rd_v   [2];
  logic [DW-1:0] out_v  [2];
  logic          valid_v[2];
  logic          busy_v [2];
  logic          msel_v [2];
  logic          ld_en   = 1'b0;
  logic [1:0]    ld_bank = '0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;

  logic [DW-1:0] model [NB][2**AW];
  exp_t          q0[$];
  exp_t          q1[$];
  logic          msel_exp[2];
  logic [DW-1:0] last_exp[2];
  int            alist[$];
  int            cyc   = 0;
  int            tests = 0;
  int            fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ld_en) model[ld_bank][ld_addr] <= ld_data;

  for (genvar g = 0; g < 2; g++) begin : gd
    banked_coderom #(.NBANKS(NB), .AW(AW), .DW(DW), .WAIT(3 * g)) u_dut (
      .clk(clk), .reset(reset), .a(a_v[g]), .ce_n(ce_v[g]), .rd(rd_v[g]),
      .out(out_v[g]), .valid(valid_v[g]), .busy(busy_v[g]), .multi_sel(msel_v[g]),
      .ld_en(ld_en), .ld_bank(ld_bank), .ld_addr(ld_addr), .ld_data(ld_data)
    );
  end

  function automatic int wt(int g);
    return 3 * g;
  endfunction

  function automatic int lowest(logic [NB-1:0] ce);
    for (int i = 0; i < NB; i++) if (!ce[i]) return i;
    return -1;
  endfunction

  task automatic check(string nm, int g, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d (wait=%0d): got %0h expected %0h at cycle %0d", nm, g, wt(g), act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int g, int bank, int addr, int due, logic msel);
    exp_t e;
    e.bank = bank; e.addr = addr; e.due = due; e.msel = msel;
    if (g == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic wait_idle(int g);
    int n = 0;
    while (busy_v[g] !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("idle_timeout", g, 32'(busy_v[g]), 0);
  endtask

  task automatic load(int bank, int addr, int data);
    ld_en = 1'b1; ld_bank = 2'(bank); ld_addr = AW'(addr); ld_data = DW'(data);
    tick();
    ld_en = 1'b0;
  endtask

  task automatic issue(int g, logic [NB-1:0] ce, int addr, bit with_ld, int lb, int la, int ldd);
    bit acc;
    wait_idle(g);
    acc = !with_ld && (ce != '1);
    a_v[g] = AW'(addr); ce_v[g] = ce; rd_v[g] = 1'b1;
    if (with_ld) begin
      ld_en = 1'b1; ld_bank = 2'(lb); ld_addr = AW'(la); ld_data = DW'(ldd);
    end
    if (acc) begin
      if ($countones(~ce) > 1) msel_exp[g] = 1'b1;
      push(g, lowest(ce), addr, cyc + 2 + wt(g), msel_exp[g]);
    end
    tick();
    rd_v[g] = 1'b0; ld_en = 1'b0;
    a_v[g]  = AW'($urandom); ce_v[g] = NB'($urandom);
    if (acc) check("busy_after_accept", g, 32'(busy_v[g]), 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < 2; g++) begin
      if (valid_v[g] === 1'b1) begin
        if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
          check("unexpected_valid", g, 32'(valid_v[g]), 0);
        end else begin
          if (g == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          check("rd_data", g, 32'(out_v[g]), 32'(model[e.bank][e.addr]));
          check("latency", g, cyc, e.due);
          check("multi_sel", g, 32'(msel_v[g]), 32'(e.msel));
          check("busy_at_valid", g, 32'(busy_v[g]), 0);
          last_exp[g] <= model[e.bank][e.addr];
        end
      end else if (g == 0 && q0.size() > 0 && cyc >= q0[0].due) begin
        check("missing_valid", g, 32'(valid_v[g]), 1);
        void'(q0.pop_front());
      end else if (g == 1 && q1.size() > 0 && cyc >= q1[0].due) begin
        check("missing_valid", g, 32'(valid_v[g]), 1);
        void'(q1.pop_front());
      end
    end
  end

  initial begin
    int            g;
    int            n;
    logic [NB-1:0] ce;
    int            addr;

    for (int i = 0; i < 2; i++) begin
      rd_v[i] = 1'b0; a_v[i] = '0; ce_v[i] = '1; msel_exp[i] = 1'b0;
    end
    for (int i = 0; i < 16; i++) alist.push_back(i);
    alist.push_back('h123); alist.push_back('h1FFE); alist.push_back('h1FFF);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("reset_out", i, 32'(out_v[i]), 0);
      check("reset_valid", i, 32'(valid_v[i]), 0);
      check("reset_busy", i, 32'(busy_v[i]), 0);
      check("reset_multi_sel", i, 32'(msel_v[i]), 0);
    end

    for (int b = 0; b < NB; b++)
      foreach (alist[k]) load(b, alist[k], int'($urandom_range(0, 255)));

    load(2, 'h123, 'hA5);
    load(0, 'h1FFF, 'h3C);
    load(0, 5, 'h11);
    load(1, 5, 'h22);
    for (int i = 0; i < 2; i++) begin
      issue(i, 4'b1011, 'h123, 0, 0, 0, 0);
      issue(i, 4'b1110, 'h1FFF, 0, 0, 0, 0);
      issue(i, 4'b0100, 5, 0, 0, 0, 0);
      issue(i, 4'b1011, 'h123, 0, 0, 0, 0);
      wait_idle(i);
      tick();
      issue(i, 4'b1111, 'h123, 0, 0, 0, 0);
      repeat (3) tick();
      check("ignored_busy", i, 32'(busy_v[i]), 0);
      check("ignored_out_hold", i, 32'(out_v[i]), 32'(last_exp[i]));
      issue(i, 4'b1101, 7, 1, 1, 7, 'h5A + i);
      repeat (3) tick();
      check("ld_block_busy", i, 32'(busy_v[i]), 0);
      issue(i, 4'b1101, 7, 0, 0, 0, 0);
    end

    wait_idle(0);
    wait_idle(1);
    tick();
    for (int i = 0; i < 2; i++) begin
      a_v[i] = 3; ce_v[i] = 4'b1110; rd_v[i] = 1'b1;
    end
    tick();
    for (int i = 0; i < 2; i++) rd_v[i] = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    q0.delete(); q1.delete();
    msel_exp[0] = 1'b0; msel_exp[1] = 1'b0;
    #1 reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("midreset_out", i, 32'(out_v[i]), 0);
      check("midreset_busy", i, 32'(busy_v[i]), 0);
      check("midreset_multi_sel", i, 32'(msel_v[i]), 0);
    end
    repeat (6) tick();
    for (int i = 0; i < 2; i++) issue(i, 4'b1110, 'h1FFF, 0, 0, 0, 0);

    for (int i = 0; i < 2; i++) begin
      wait_idle(i);
      rd_v[i] = 1'b1; ce_v[i] = 4'b0111;
      for (int k = 0; k < 3; k++) begin
        a_v[i] = AW'(k);
        push(i, 3, k, cyc + 2 + wt(i), msel_exp[i]);
        repeat (2 + wt(i)) tick();
      end
      rd_v[i] = 1'b0;
    end

    repeat (60) begin
      g    = int'($urandom_range(0, 1));
      ce   = NB'($urandom);
      addr = alist[$urandom_range(0, alist.size() - 1)];
      if ($urandom_range(0, 9) == 0)
        issue(g, ce, addr, 1, int'($urandom_range(0, 3)), addr, int'($urandom_range(0, 255)));
      else
        issue(g, ce, addr, 0, 0, 0, 0);
      if ($urandom_range(0, 2) == 0)
        load(int'($urandom_range(0, 3)),
             ($urandom_range(0, 1) == 0) ? addr : alist[$urandom_range(0, alist.size() - 1)],
             int'($urandom_range(0, 255)));
    end

    n = 0;
    while ((q0.size() + q1.size()) > 0 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("drain", 0, 32'(q0.size() + q1.size()), 0);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
